// File: rtl/instruction_fetch_stage_pkg.sv
// Shared widths, constants and helpers for the fetch stage and the pipeline
// registers that follow it.
package instruction_fetch_stage_pkg;

   localparam int WORD_W      = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [WORD_W-1:0] DEFAULT_NOP_WORD = 32'h0000_0000;
   localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_HOLD,
      PC_JUMP,
      PC_BRANCH,
      PC_SEQ
   } pc_sel_e;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc_plus4;
      logic              valid;
   } if_id_t;

   // Misaligned redirect targets are silently forced onto a word boundary.
   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: holds on stall, loads a bubble on flush,
// otherwise captures the fetched instruction and its PC+4.
module if_id_register
   import instruction_fetch_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic [WORD_W-1:0] instr_i,
   input  logic [WORD_W-1:0] pc_plus4_i,
   output logic [WORD_W-1:0] instr_o,
   output logic [WORD_W-1:0] pc_plus4_o,
   output logic              valid_o
);

   localparam if_id_t BUBBLE = '{instr: NOP_WORD, pc_plus4: '0, valid: 1'b0};

   if_id_t if_id_d;
   if_id_t if_id_q;

   always_comb begin
      // NOTE: assigning the hold value first means every path drives if_id_d, so no latch is inferred.
      if_id_d = if_id_q;
      if (!stall) begin
         if (flush) begin
            if_id_d = BUBBLE;
         end else begin
            if_id_d = '{instr: instr_i, pc_plus4: pc_plus4_i, valid: 1'b1};
         end
      end
   end

   // NOTE: non-blocking assignment keeps every flop sampling pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_q <= BUBBLE;
      end else begin
         if_id_q <= if_id_d;
      end
   end

   assign instr_o    = if_id_q.instr;
   assign pc_plus4_o = if_id_q.pc_plus4;
   assign valid_o    = if_id_q.valid;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: program counter with stall/jump/branch selection,
// fetch address to instruction memory, IF/ID register and fetch counter.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [WORD_W-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              PCSrc,
   input  logic [WORD_W-1:0] BranchTarget,
   input  logic              Jump,
   input  logic [WORD_W-1:0] JumpTarget,
   input  logic [WORD_W-1:0] Instruction,
   output logic [WORD_W-1:0] Address,
   output logic [WORD_W-1:0] IF_ID_Instruction,
   output logic [WORD_W-1:0] IF_ID_PCPlus4,
   output logic              IF_ID_Valid,
   output logic [WORD_W-1:0] FetchCount
);

   logic [WORD_W-1:0] pc_d, pc_q;
   logic [WORD_W-1:0] fetch_count_d, fetch_count_q;
   logic [WORD_W-1:0] pc_plus4;
   pc_sel_e           pc_sel;

   assign pc_plus4 = pc_q + WORD_W'(INSTR_BYTES);

   // Stall outranks any redirect; Jump outranks a taken branch.
   always_comb begin
      pc_sel = PC_SEQ;
      if (Stall) begin
         pc_sel = PC_HOLD;
      end else if (Jump) begin
         pc_sel = PC_JUMP;
      end else if (PCSrc) begin
         pc_sel = PC_BRANCH;
      end
   end

   always_comb begin
      pc_d = pc_q;
      unique case (pc_sel)
         PC_HOLD:   pc_d = pc_q;
         PC_JUMP:   pc_d = word_align(JumpTarget);
         PC_BRANCH: pc_d = word_align(BranchTarget);
         PC_SEQ:    pc_d = pc_plus4;
         default:   pc_d = pc_q;
      endcase
   end

   always_comb begin
      fetch_count_d = fetch_count_q;
      if (!Stall && !Flush) begin
         fetch_count_d = fetch_count_q + WORD_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc_q          <= RESET_PC;
         fetch_count_q <= '0;
      end else begin
         pc_q          <= pc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   if_id_register #(
      .NOP_WORD (NOP_WORD)
   ) u_if_id (
      .clk        (Clk),
      .rst_n      (Reset),
      .stall      (Stall),
      .flush      (Flush),
      .instr_i    (Instruction),
      .pc_plus4_i (pc_plus4),
      .instr_o    (IF_ID_Instruction),
      .pc_plus4_o (IF_ID_PCPlus4),
      .valid_o    (IF_ID_Valid)
   );

   assign Address    = pc_q;
   assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed testbench for instruction_fetch_stage with a combinational
// instruction memory model; expected values are hand-computed constants.
module tb_instruction_fetch_stage;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Stall;
   logic        Flush;
   logic        PCSrc;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic [31:0] Instruction;
   logic [31:0] Address;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PCPlus4;
   logic        IF_ID_Valid;
   logic [31:0] FetchCount;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] cnt;
   } obs_t;

   instruction_fetch_stage dut (
      .Clk               (Clk),
      .Reset             (Reset),
      .Stall             (Stall),
      .Flush             (Flush),
      .PCSrc             (PCSrc),
      .BranchTarget      (BranchTarget),
      .Jump              (Jump),
      .JumpTarget        (JumpTarget),
      .Instruction       (Instruction),
      .Address           (Address),
      .IF_ID_Instruction (IF_ID_Instruction),
      .IF_ID_PCPlus4     (IF_ID_PCPlus4),
      .IF_ID_Valid       (IF_ID_Valid),
      .FetchCount        (FetchCount)
   );

   always #5 Clk = ~Clk;

   // Memory word k (byte address 4k) is 0x20080001 + k*0x00010001.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h2008_0001 + (a >> 2) * 32'h0001_0001;
   endfunction

   assign Instruction = mem_word(Address);

   function automatic obs_t observe();
      return '{addr: Address, instr: IF_ID_Instruction, pc4: IF_ID_PCPlus4,
               valid: IF_ID_Valid, cnt: FetchCount};
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("addr=%h instr=%h pc4=%h valid=%0b cnt=%0d",
                       o.addr, o.instr, o.pc4, o.valid, o.cnt);
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      Stall = 0; Flush = 0; PCSrc = 0; Jump = 0;
      BranchTarget = '0; JumpTarget = '0;
   endtask

   task automatic test_reset();
      obs_t got, exp;
      idle_inputs();
      Reset = 0;
      #2;
      got = observe();
      exp = '{addr: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, cnt: 32'd0};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL reset_state: got %s, expected %s", fmt(got), fmt(exp));
      end
      tick();
      Reset = 1;
   endtask

   task automatic test_free_run();
      obs_t got, exp;
      tick();
      got = observe();
      exp = '{addr: 32'h4, instr: 32'h2008_0001, pc4: 32'h4, valid: 1'b1, cnt: 32'd1};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL free_run_edge1: got %s, expected %s", fmt(got), fmt(exp));
      end
      tick();
      got = observe();
      exp = '{addr: 32'h8, instr: 32'h2009_0002, pc4: 32'h8, valid: 1'b1, cnt: 32'd2};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL free_run_edge2: got %s, expected %s", fmt(got), fmt(exp));
      end
   endtask

   task automatic test_stall();
      obs_t got, exp;
      Stall = 1;
      exp = '{addr: 32'h8, instr: 32'h2009_0002, pc4: 32'h8, valid: 1'b1, cnt: 32'd2};
      for (int i = 0; i < 3; i++) begin
         tick();
         got = observe();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL stall_hold_%0d: got %s, expected %s", i, fmt(got), fmt(exp));
         end
      end
      Stall = 0;
      tick();
      got = observe();
      exp = '{addr: 32'hC, instr: 32'h200A_0003, pc4: 32'hC, valid: 1'b1, cnt: 32'd3};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL stall_release: got %s, expected %s", fmt(got), fmt(exp));
      end
   endtask

   task automatic test_branch_flush();
      obs_t got, exp;
      PCSrc = 1; BranchTarget = 32'h40; Flush = 1;
      tick();
      got = observe();
      exp = '{addr: 32'h40, instr: 32'h0, pc4: 32'h0, valid: 1'b0, cnt: 32'd3};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL branch_flush: got %s, expected %s", fmt(got), fmt(exp));
      end
      idle_inputs();
      tick();
      got = observe();
      exp = '{addr: 32'h44, instr: 32'h2018_0011, pc4: 32'h44, valid: 1'b1, cnt: 32'd4};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL branch_target_fetch: got %s, expected %s", fmt(got), fmt(exp));
      end
   endtask

   task automatic test_jump();
      obs_t got, exp;
      Jump = 1; JumpTarget = 32'h100; PCSrc = 1; BranchTarget = 32'h40;
      tick();
      got = observe();
      exp = '{addr: 32'h100, instr: 32'h2019_0012, pc4: 32'h48, valid: 1'b1, cnt: 32'd5};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL jump_over_branch: got %s, expected %s", fmt(got), fmt(exp));
      end
      PCSrc = 0; JumpTarget = 32'h103;
      tick();
      got = observe();
      exp = '{addr: 32'h100, instr: 32'h2048_0041, pc4: 32'h104, valid: 1'b1, cnt: 32'd6};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL jump_misaligned: got %s, expected %s", fmt(got), fmt(exp));
      end
      idle_inputs();
   endtask

   task automatic test_stall_priority();
      obs_t got, exp;
      Stall = 1; Flush = 1; PCSrc = 1; BranchTarget = 32'h40;
      tick();
      got = observe();
      exp = '{addr: 32'h100, instr: 32'h2048_0041, pc4: 32'h104, valid: 1'b1, cnt: 32'd6};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL stall_over_flush_branch: got %s, expected %s", fmt(got), fmt(exp));
      end
      idle_inputs();
      tick();
      got = observe();
      exp = '{addr: 32'h104, instr: 32'h2048_0041, pc4: 32'h104, valid: 1'b1, cnt: 32'd7};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL redirect_dropped: got %s, expected %s", fmt(got), fmt(exp));
      end
   endtask

   task automatic test_async_reset();
      obs_t got, exp;
      Reset = 0;
      #2;
      Reset = 1;
      for (int i = 0; i < 8; i++) tick();
      got = observe();
      exp = '{addr: 32'h20, instr: 32'h200F_0008, pc4: 32'h20, valid: 1'b1, cnt: 32'd8};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL pre_reset_state: got %s, expected %s", fmt(got), fmt(exp));
      end
      #2;
      Reset = 0;
      #1;
      got = observe();
      exp = '{addr: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, cnt: 32'd0};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL async_reset_immediate: got %s, expected %s", fmt(got), fmt(exp));
      end
      #1;
      Reset = 1;
      tick();
      got = observe();
      exp = '{addr: 32'h4, instr: 32'h2008_0001, pc4: 32'h4, valid: 1'b1, cnt: 32'd1};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL restart_after_reset: got %s, expected %s", fmt(got), fmt(exp));
      end
   endtask

   task automatic test_pc_wrap();
      Jump = 1; JumpTarget = 32'hFFFF_FFFC;
      tick();
      Jump = 0;
      checks++;
      if (Address !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_jump: got addr=%h, expected addr=fffffffc", Address);
      end
      tick();
      checks++;
      if (Address !== 32'h0 || IF_ID_PCPlus4 !== 32'h0 || IF_ID_Valid !== 1'b1) begin
         errors++;
         $display("FAIL pc_wrap: got addr=%h pc4=%h valid=%0b, expected addr=0 pc4=0 valid=1",
                  Address, IF_ID_PCPlus4, IF_ID_Valid);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_branch_flush();
      test_jump();
      test_stall_priority();
      test_async_reset();
      test_pc_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
